// File: rtl/ahbl_sram_ctrl_gen2.sv
// AHB-Lite slave in front of an inferred single-port synchronous SRAM.
// Writes are posted through a one-entry byte-lane buffer that is forwarded
// into reads of the same word. Illegal transfers get a two-cycle ERROR response.
module ahbl_sram_ctrl_gen2 #(
  parameter int AHB_DWIDTH = 32,
  parameter int AHB_AWIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int RD_WAIT    = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic                  HREADYIN,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HBURST,
  input  logic [2:0]            HSIZE,
  input  logic [AHB_AWIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [AHB_DWIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [AHB_DWIDTH-1:0] HRDATA,
  output logic                  BUSY
);

  localparam int NBYTES = AHB_DWIDTH / 8;
  localparam int OFFW   = $clog2(NBYTES);
  localparam int IDXW   = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_RDW, S_ERR1, S_ERR2} state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [IDXW-1:0]       idx_q;
  logic [NBYTES-1:0]     strb_q;
  logic                  write_q;
  logic                  buf_valid_q;
  logic [IDXW-1:0]       buf_idx_q;
  logic [NBYTES-1:0]     buf_strb_q;
  logic [AHB_DWIDTH-1:0] buf_data_q;
  logic [AHB_DWIDTH-1:0] hrdata_q;

  logic [OFFW-1:0]       hoff;
  logic [IDXW-1:0]       hidx;
  logic [OFFW-1:0]       align_mask;
  logic [NBYTES-1:0]     hstrb;
  logic                  legal, accept, rd_issue, rd_pend, drain, wr_done, fwd_hit;
  logic [IDXW-1:0]       ram_idx;
  logic [AHB_DWIDTH-1:0] ram_q;
  logic [AHB_DWIDTH-1:0] rd_merged;
  logic                  unused_ok;

  // Burst type, HTRANS[0] and the address bits above the word index carry no meaning here
  assign unused_ok = ^{HBURST, HTRANS[0], HADDR};

  assign hoff = HADDR[OFFW-1:0];
  assign hidx = HADDR[IDXW+OFFW-1:OFFW];

  // Low address bits that must be zero for the requested size, and the lanes that size covers
  for (genvar gi = 0; gi < OFFW; gi++) begin : g_mask
    assign align_mask[gi] = (HSIZE > 3'(gi));
  end
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_strb
    assign hstrb[gi] = ((OFFW'(gi) & ~align_mask) == hoff);
  end

  assign legal    = (HSIZE <= 3'(OFFW)) && ((hoff & align_mask) == '0);
  assign accept   = HSEL & HREADYIN & HTRANS[1] & HREADYOUT;
  assign rd_issue = accept & legal & ~HWRITE;
  // Read request seen without HREADYIN so a looped-back HREADYOUT cannot form a combinational loop
  assign rd_pend  = HSEL & HTRANS[1] & ~HWRITE;
  assign drain    = buf_valid_q & ~rd_issue;
  assign wr_done  = (state_q == S_DATA) & write_q & HREADYOUT;
  assign fwd_hit  = buf_valid_q & (buf_idx_q == idx_q);
  assign ram_idx  = rd_issue ? hidx : buf_idx_q;

  // One byte-wide RAM per lane: lane-gated drain writes, registered reads on read issue
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] lane_q;
    always_ff @(posedge HCLK) begin
      if (drain && buf_strb_q[gi]) mem[ram_idx] <= buf_data_q[8*gi +: 8];
      if (rd_issue) lane_q <= mem[ram_idx];
    end
    assign ram_q[8*gi +: 8]     = lane_q;
    assign rd_merged[8*gi +: 8] = (fwd_hit && buf_strb_q[gi]) ? buf_data_q[8*gi +: 8] : lane_q;
  end

  // Response: ready/resp follow the current data-phase state
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 2'b00;
    case (state_q)
      S_DATA: begin
        if (write_q) HREADYOUT = ~(buf_valid_q & rd_pend);
        else         HREADYOUT = (RD_WAIT == 0);
      end
      S_RDW:  HREADYOUT = (cnt_q == 2'(RD_WAIT));
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b01;
      end
      S_ERR2: HRESP = 2'b01;
      default: ;
    endcase
  end

  // Next state: a completing cycle moves to the next accepted transfer, otherwise progress the wait
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (HREADYOUT) begin
      if (accept) state_d = legal ? S_DATA : S_ERR1;
      else        state_d = S_IDLE;
    end else begin
      case (state_q)
        S_DATA: begin
          if (!write_q) begin
            state_d = S_RDW;
            cnt_d   = 2'd1;
          end
        end
        S_RDW:  cnt_d   = cnt_q + 2'd1;
        S_ERR1: state_d = S_ERR2;
        default: ;
      endcase
    end
  end

  // FSM state and read wait counter
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address-phase capture
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      idx_q   <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
    end else if (accept) begin
      idx_q   <= hidx;
      strb_q  <= hstrb;
      write_q <= HWRITE;
    end
  end

  // Posted write buffer: load at end of write data phase, empty when drained
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      buf_valid_q <= 1'b0;
      buf_idx_q   <= '0;
      buf_strb_q  <= '0;
      buf_data_q  <= '0;
    end else if (wr_done) begin
      buf_valid_q <= 1'b1;
      buf_idx_q   <= idx_q;
      buf_strb_q  <= strb_q;
      buf_data_q  <= HWDATA;
    end else if (drain) begin
      buf_valid_q <= 1'b0;
    end
  end

  // Read data holding register, captured in the first read data-phase cycle
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                                hrdata_q <= '0;
    else if (state_q == S_DATA && !write_q)    hrdata_q <= rd_merged;
  end

  assign HRDATA = (state_q == S_DATA && !write_q) ? rd_merged : hrdata_q;
  assign BUSY   = buf_valid_q | (state_q != S_IDLE);

endmodule

// File: tb/tb_ahbl_sram_ctrl_gen2.sv
// Directed bench: one instance with no read wait states, one with two.
// Both share the bus inputs; each has its own HSEL and loops HREADYOUT to HREADYIN.
module tb_ahbl_sram_ctrl_gen2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel0, sel2;
  logic [1:0]  htrans;
  logic [2:0]  hburst, hsize;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic        rdy0, rdy2, busy0, busy2;
  logic [1:0]  resp0, resp2;
  logic [31:0] rdata0, rdata2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ahbl_sram_ctrl_gen2 #(.AHB_DWIDTH(32), .AHB_AWIDTH(32), .DEPTH(512), .RD_WAIT(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HREADYIN(rdy0), .HTRANS(htrans),
    .HBURST(hburst), .HSIZE(hsize), .HADDR(haddr), .HWRITE(hwrite), .HWDATA(hwdata),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0), .BUSY(busy0));

  ahbl_sram_ctrl_gen2 #(.AHB_DWIDTH(32), .AHB_AWIDTH(32), .DEPTH(512), .RD_WAIT(2)) dut2 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel2), .HREADYIN(rdy2), .HTRANS(htrans),
    .HBURST(hburst), .HSIZE(hsize), .HADDR(haddr), .HWRITE(hwrite), .HWDATA(hwdata),
    .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rdata2), .BUSY(busy2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic addr_ph(input logic s0, input logic s2, input logic wr,
                         input logic [2:0] sz, input logic [31:0] a);
    sel0   = s0;
    sel2   = s2;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
  endtask

  task automatic idle();
    sel0   = 1'b0;
    sel2   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Word write followed by an idle cycle so the posted entry drains
  task automatic do_write(input logic s0, input logic s2, input logic [31:0] a, input logic [31:0] d);
    addr_ph(s0, s2, 1'b1, 3'd2, a);
    tick();
    idle();
    hwdata = d;
    tick();
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    hburst = 3'b001;
    hsize  = 3'd2;
    haddr  = 32'h0;
    hwdata = 32'h0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    smp();
    chk("rst_ready0", {31'd0, rdy0}, 32'd1);
    chk("rst_resp0", {30'd0, resp0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    chk("rst_rdata2", rdata2, 32'h0);
    tick();

    // Back-to-back word write then read of 0x10
    addr_ph(1, 0, 1'b1, 3'd2, 32'h10);
    smp(); chk("b2b_idle_ready", {31'd0, rdy0}, 32'd1);
    tick();
    hwdata = 32'hA5A5_1234;
    addr_ph(1, 0, 1'b0, 3'd2, 32'h10);
    smp(); chk("b2b_wr_ready", {31'd0, rdy0}, 32'd1);
    chk("b2b_wr_busy", {31'd0, busy0}, 32'd1);
    tick();
    idle();
    smp(); chk("b2b_rd_ready", {31'd0, rdy0}, 32'd1);
    chk("b2b_rd_data", rdata0, 32'hA5A5_1234);
    tick();
    smp(); chk("b2b_busy_clear", {31'd0, busy0}, 32'd0);
    chk("b2b_rdata_hold", rdata0, 32'hA5A5_1234);
    tick();

    // Byte writes over 0xFFFFFFFF at 0x20, read back merges buffer and RAM
    addr_ph(1, 0, 1'b1, 3'd2, 32'h20);
    tick();
    hwdata = 32'hFFFF_FFFF;
    addr_ph(1, 0, 1'b1, 3'd0, 32'h21);
    smp(); chk("byte_w0_ready", {31'd0, rdy0}, 32'd1);
    tick();
    hwdata = 32'h1111_1111;
    addr_ph(1, 0, 1'b1, 3'd0, 32'h23);
    smp(); chk("byte_w1_ready", {31'd0, rdy0}, 32'd1);
    tick();
    hwdata = 32'h2222_2222;
    addr_ph(1, 0, 1'b0, 3'd2, 32'h20);
    smp(); chk("byte_w2_stall", {31'd0, rdy0}, 32'd0);
    tick();
    smp(); chk("byte_w2_done", {31'd0, rdy0}, 32'd1);
    tick();
    idle();
    smp(); chk("byte_rd_data", rdata0, 32'h22FF_11FF);
    chk("byte_rd_ready", {31'd0, rdy0}, 32'd1);
    tick();
    tick();

    // Illegal transfers: misaligned halfword and doubleword on a 32-bit bus
    do_write(1, 0, 32'h0, 32'hCAFE_BABE);
    addr_ph(1, 0, 1'b1, 3'd1, 32'h1);
    smp(); chk("err_hw_accept_ready", {31'd0, rdy0}, 32'd1);
    tick();
    idle();
    hwdata = 32'hFFFF_FFFF;
    smp(); chk("err_hw_c1_ready", {31'd0, rdy0}, 32'd0);
    chk("err_hw_c1_resp", {30'd0, resp0}, 32'd1);
    tick();
    addr_ph(1, 0, 1'b1, 3'd3, 32'h0);
    smp(); chk("err_hw_c2_ready", {31'd0, rdy0}, 32'd1);
    chk("err_hw_c2_resp", {30'd0, resp0}, 32'd1);
    tick();
    idle();
    smp(); chk("err_dw_c1_ready", {31'd0, rdy0}, 32'd0);
    chk("err_dw_c1_resp", {30'd0, resp0}, 32'd1);
    tick();
    addr_ph(1, 0, 1'b0, 3'd2, 32'h0);
    smp(); chk("err_dw_c2_ready", {31'd0, rdy0}, 32'd1);
    chk("err_dw_c2_resp", {30'd0, resp0}, 32'd1);
    tick();
    idle();
    smp(); chk("err_mem_unchanged", rdata0, 32'hCAFE_BABE);
    chk("err_after_resp", {30'd0, resp0}, 32'd0);
    tick();

    // Pipelined W@0x0, W@0x4, R@0x8 with the buffer full
    do_write(1, 0, 32'h8, 32'h8888_8888);
    addr_ph(1, 0, 1'b1, 3'd2, 32'h0);
    tick();
    hwdata = 32'h0102_0304;
    addr_ph(1, 0, 1'b1, 3'd2, 32'h4);
    smp(); chk("pipe_w0_ready", {31'd0, rdy0}, 32'd1);
    tick();
    hwdata = 32'h0506_0708;
    addr_ph(1, 0, 1'b0, 3'd2, 32'h8);
    smp(); chk("pipe_w1_stall", {31'd0, rdy0}, 32'd0);
    tick();
    smp(); chk("pipe_w1_done", {31'd0, rdy0}, 32'd1);
    tick();
    idle();
    smp(); chk("pipe_rd8_data", rdata0, 32'h8888_8888);
    chk("pipe_rd8_ready", {31'd0, rdy0}, 32'd1);
    tick();
    addr_ph(1, 0, 1'b0, 3'd2, 32'h0);
    tick();
    addr_ph(1, 0, 1'b0, 3'd2, 32'h4);
    smp(); chk("pipe_rd0_data", rdata0, 32'h0102_0304);
    tick();
    idle();
    smp(); chk("pipe_rd4_data", rdata0, 32'h0506_0708);
    tick();

    // Two read wait states
    do_write(0, 1, 32'h4, 32'h4433_2211);
    addr_ph(0, 1, 1'b0, 3'd2, 32'h4);
    smp(); chk("rw2_accept_ready", {31'd0, rdy2}, 32'd1);
    tick();
    idle();
    smp(); chk("rw2_wait1", {31'd0, rdy2}, 32'd0);
    tick();
    smp(); chk("rw2_wait2", {31'd0, rdy2}, 32'd0);
    tick();
    smp(); chk("rw2_done_ready", {31'd0, rdy2}, 32'd1);
    chk("rw2_data", rdata2, 32'h4433_2211);
    tick();

    // Reset asserted in the middle of a read wait
    addr_ph(0, 1, 1'b0, 3'd2, 32'h4);
    tick();
    idle();
    smp(); chk("mid_wait_ready", {31'd0, rdy2}, 32'd0);
    chk("mid_wait_busy", {31'd0, busy2}, 32'd1);
    tick();
    rst = 1'b1;
    smp(); chk("mid_rst_ready", {31'd0, rdy2}, 32'd1);
    chk("mid_rst_resp", {30'd0, resp2}, 32'd0);
    chk("mid_rst_rdata", rdata2, 32'h0);
    chk("mid_rst_busy", {31'd0, busy2}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
